// File: rtl/track_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : track_sequencer
// Description : Row/tick song sequencer that scans a pattern ROM per row and
//               issues note-on/note-off commands over a valid/ready channel.
//               Optional macro SEQ_LOOP_ROW_EN adds loop_row (end-of-song
//               jump target).
// Revision    : 1.0 - initial release
// ============================================================================
module track_sequencer #(
  parameter int NUM_VOICES    = 4,
  parameter int ROW_BITS      = 6,
  parameter int TICKS_PER_ROW = 6,
  parameter int NOTE_BITS     = 6,
  localparam int VOICE_BITS   = $clog2(NUM_VOICES),
  localparam int TICK_BITS    = $clog2(TICKS_PER_ROW)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic                           pause,
  input  logic                           restart,
`ifdef SEQ_LOOP_ROW_EN
  input  logic [ROW_BITS-1:0]            loop_row,
`endif
  output logic [ROW_BITS+VOICE_BITS-1:0] rom_addr,
  input  logic [NOTE_BITS+1:0]           rom_data,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [VOICE_BITS-1:0]          cmd_voice,
  output logic [NOTE_BITS-1:0]           cmd_note,
  output logic                           cmd_gate,
  output logic [ROW_BITS-1:0]            row,
  output logic [TICK_BITS-1:0]           tick_count,
  output logic                           busy,
  output logic                           song_wrap,
  output logic                           overrun
);

  localparam logic [TICK_BITS-1:0]  c_TICK_LAST  = TICK_BITS'(TICKS_PER_ROW - 1);
  localparam logic [VOICE_BITS-1:0] c_VOICE_LAST = VOICE_BITS'(NUM_VOICES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_NEXT  = 3'd4,
    S_END   = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [VOICE_BITS-1:0]   r_voice;
  logic [VOICE_BITS-1:0]   w_addr_voice;
  logic [ROW_BITS-1:0]     r_row;
  logic [ROW_BITS-1:0]     r_scan_row;
  logic [ROW_BITS-1:0]     r_pend_row;
  logic [ROW_BITS-1:0]     w_wrap_row;
  logic [TICK_BITS-1:0]    r_tick;
  logic                    r_pending;
  logic                    r_overrun;
  logic                    r_end_flag;
  logic [VOICE_BITS-1:0]   r_cmd_voice;
  logic [NOTE_BITS-1:0]    r_cmd_note;
  logic                    r_cmd_gate;
  logic [1:0]              w_kind;
  logic                    w_tick_acc;
  logic                    w_scan_req;
  logic                    w_last_voice;
  logic                    w_wrap;

  assign w_tick_acc   = frame_tick && !pause && !restart;
  assign w_scan_req   = w_tick_acc && (r_tick == '0);
  assign w_kind       = rom_data[NOTE_BITS+1:NOTE_BITS];
  assign w_last_voice = (r_voice == c_VOICE_LAST);
  assign w_wrap       = (r_state == S_END) && r_end_flag;

`ifdef SEQ_LOOP_ROW_EN
  assign w_wrap_row = loop_row;
`else
  assign w_wrap_row = '0;
`endif

  // NEXT already presents the following voice's address, so the ROM read
  // overlaps the advance and the next visit goes straight to WAIT.
  assign w_addr_voice = (r_state == S_NEXT) ? (r_voice + VOICE_BITS'(1)) : r_voice;
  assign rom_addr     = {r_scan_row, w_addr_voice};

  assign cmd_valid  = (r_state == S_ISSUE);
  assign cmd_voice  = r_cmd_voice;
  assign cmd_note   = r_cmd_note;
  assign cmd_gate   = r_cmd_gate;
  assign row        = r_row;
  assign tick_count = r_tick;
  assign busy       = (r_state != S_IDLE);
  assign song_wrap  = w_wrap;
  assign overrun    = r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_scan_req || r_pending) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_kind == 2'b01 || w_kind == 2'b10) w_state_next = S_ISSUE;
        else                                    w_state_next = S_NEXT;
      end
      S_ISSUE: if (cmd_ready) w_state_next = S_NEXT;
      S_NEXT:  w_state_next = w_last_voice ? S_END : S_WAIT;
      S_END:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (restart) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row       <= '0;
      r_tick      <= '0;
      r_voice     <= '0;
      r_scan_row  <= '0;
      r_pend_row  <= '0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_end_flag  <= 1'b0;
      r_cmd_voice <= '0;
      r_cmd_note  <= '0;
      r_cmd_gate  <= 1'b0;
    end else begin
      // The end-of-song jump overrides any tick landing in the same cycle.
      if (restart) begin
        r_row  <= '0;
        r_tick <= '0;
      end else if (w_wrap) begin
        r_row  <= w_wrap_row;
        r_tick <= '0;
      end else if (w_tick_acc) begin
        if (r_tick == c_TICK_LAST) begin
          r_tick <= '0;
          r_row  <= r_row + ROW_BITS'(1);
        end else begin
          r_tick <= r_tick + TICK_BITS'(1);
        end
      end

      if (restart) begin
        r_pending  <= 1'b0;
        r_overrun  <= 1'b0;
        r_end_flag <= 1'b0;
      end else begin
        if (r_state == S_IDLE) begin
          if (r_pending) begin
            r_scan_row <= r_pend_row;
            r_voice    <= '0;
            r_pending  <= w_scan_req;
            if (w_scan_req) r_pend_row <= r_row;
          end else if (w_scan_req) begin
            r_scan_row <= r_row;
            r_voice    <= '0;
          end
        end else if (w_scan_req) begin
          if (r_pending) begin
            r_overrun <= 1'b1;
          end else begin
            r_pending  <= 1'b1;
            r_pend_row <= r_row;
          end
        end

        case (r_state)
          S_WAIT: begin
            if (w_kind == 2'b01 || w_kind == 2'b10) begin
              r_cmd_voice <= r_voice;
              r_cmd_note  <= rom_data[NOTE_BITS-1:0];
              r_cmd_gate  <= (w_kind == 2'b01);
            end else if (w_kind == 2'b11) begin
              r_end_flag <= 1'b1;
            end
          end
          S_NEXT: if (!w_last_voice) r_voice <= r_voice + VOICE_BITS'(1);
          S_END:  r_end_flag <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
